axi_lite_data_sorter: RTL and testbench
=======================================

Name: axi_lite_data_sorter

Overview:
- AXI4-Lite-style write-only slave that sorts incoming 32-bit write data into two FIFOs.
- A write to the data port (0x04) whose tag byte WDATA[31:24] equals 0xA5 goes to the "valid" FIFO; any other tag goes to the "invalid" FIFO.
- A write to 0x00 updates a mirror register `mem`.
- The block sits as a self-issuing sink: it generates its own AWVALID/WVALID/BREADY, so a bench only drives address, data and enables, one write per clock.

Parameters:
- WIDTH, 32, data width of WDATA, `mem` and the FIFO entries.
- DEPTH, 10, FIFO capacity in entries; also the bit width of each occupancy counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- AWADDR  in  32  write address.
- WDATA  in  32  write data; [31:24] is the tag byte.
- val_wr_en  in  1  push enable for the valid FIFO.
- ival_wr_en  in  1  push enable for the invalid FIFO.
- AWVALID  out  1  self-issued address valid.
- WVALID  out  1  self-issued data valid.
- AWREADY  out  1  address ready.
- WREADY  out  1  data ready.
- BVALID  out  1  write response valid.
- BREADY  out  1  response ready; constant 1 out of reset.
- BRESP  out  2  write response code.
- mem  out  WIDTH  last data written to 0x00; declared [0:WIDTH-1] so mem[0] is the MSB.
- val_fifo_ctr  out  DEPTH  valid FIFO occupancy.
- ival_fifo_ctr  out  DEPTH  invalid FIFO occupancy.
- val_full, val_empty, ival_full, ival_empty  out  1 each  FIFO status flags.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - AWVALID, WVALID, AWREADY, WREADY, BVALID, BREADY to 0; BRESP to 00.
  - mem, both counters and both FIFO pointers to 0.
  - val_empty and ival_empty to 1; val_full and ival_full to 0.
- After reset release:
  - AWVALID, WVALID, AWREADY, WREADY and BREADY are 1 on every cycle.
  - A write handshake completes on every rising edge, so throughput is one write per clock.
- Decode of each accepted write (sampled at edge n):
  - AWADDR==0x00: mem <= WDATA. BRESP=OKAY(00).
  - AWADDR==0x04 and WDATA[31:24]==8'hA5: push WDATA into the valid FIFO if val_wr_en=1 and not val_full.
  - AWADDR==0x04 and any other tag: push WDATA into the invalid FIFO if ival_wr_en=1 and not ival_full.
  - AWADDR==0x04 response: OKAY if pushed. SLVERR(10) if the target FIFO is full. OKAY with no push if the matching enable is 0.
  - Any other address: no state change, BRESP=SLVERR(10).
- Response timing: BVALID=1 and BRESP valid in the cycle after edge n (registered). BREADY=1 means every response completes in one cycle, so BVALID stays high during continuous traffic.
- FIFO rules:
  - Counter increments by 1 on each push and saturates at DEPTH; it never wraps.
  - full = (ctr==DEPTH); empty = (ctr==0).
  - Write pointer wraps from DEPTH-1 to 0.
  - Counter and flag updates are visible the cycle after the push edge.
- Only one FIFO can be pushed per cycle; the two FIFOs are mutually exclusive by decode.
- Reset asserted mid-traffic clears everything immediately; an in-flight response is discarded.

Optional Feature:
- Macro: SORTER_READ_PORT_EN.
- When defined, the block adds:
  - Inputs val_rd_en and ival_rd_en (1 bit each).
  - Outputs val_rdata and ival_rdata (WIDTH each), registered.
- Read behaviour with the macro:
  - Pop when the read enable is 1 and the FIFO is not empty; read data updates the next cycle.
  - Pop from an empty FIFO is ignored and holds the read data.
  - A simultaneous push and pop leaves the counter unchanged; both pointers advance.
- When not defined, the FIFOs are write-only, the counters only increment or saturate, and the read ports are absent.

Decomposition:
- Package sorter_pkg holds:
  - ADDR_MEM=32'h00 and ADDR_DATA=32'h04.
  - VALID_TAG=8'hA5.
  - BRESP_OKAY=2'b00 and BRESP_SLVERR=2'b10.
- Sub-module sorter_fifo (parameters WIDTH, DEPTH) is instantiated twice, once as the valid FIFO and once as the invalid FIFO. Each instance provides storage, pointers, counter and flags.

Test Plan:
- Reset, then writes to 0x04 with tags A5, A4, 00, A2 and enables at 1 → val_fifo_ctr=1, ival_fifo_ctr=3; val_empty=0; BRESP=00 each cycle.
- Write 0x00 with WDATA=32'hA6000000 → mem=32'hA6000000 next cycle. Follow with a 0x04 write of the same data → ival_fifo_ctr increments and val_fifo_ctr is unchanged.
- Ten consecutive 0x04 writes of tag A5 → val_fifo_ctr=10 and val_full=1. An eleventh A5 write → counter stays 10 and BRESP=10.
- val_wr_en=0 with a 0x04 tag A5 write → no push and BRESP=00. AWADDR=0x08 → BRESP=10, and mem and counters are unchanged.
- Drive rst=0 mid-stream → all outputs reach their reset values without waiting for a clock edge. After release, the first write at the next edge is accepted.
- With SORTER_READ_PORT_EN defined: push A5000001 and A5000002, then val_rd_en=1 for two cycles → val_rdata returns them in that order, val_fifo_ctr goes 2→1→0, and val_empty=1.

Source files
------------

// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - address map, tag and response codes shared by the sorter
package sorter_pkg;

   localparam logic [31:0] ADDR_MEM     = 32'h0000_0000;
   localparam logic [31:0] ADDR_DATA    = 32'h0000_0004;
   localparam logic [7:0]  VALID_TAG    = 8'hA5;
   localparam logic [1:0]  BRESP_OKAY   = 2'b00;
   localparam logic [1:0]  BRESP_SLVERR = 2'b10;

   // A data-port write is refused only when it was enabled and its FIFO had no room.
   function automatic logic [1:0] push_resp(input logic en, input logic full);
      return (en && full) ? BRESP_SLVERR : BRESP_OKAY;
   endfunction

endpackage

// File: rtl/sorter_fifo.sv
// rtl/sorter_fifo.sv - saturating FIFO with occupancy counter and flags
// Read port present only when SORTER_READ_PORT_EN is defined.
module sorter_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
`ifdef SORTER_READ_PORT_EN
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
`endif
   output logic [DEPTH-1:0] ctr_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int                PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DEPTH-1:0]  CTR_MAX = DEPTH'(DEPTH);
   localparam logic [PW-1:0]     PTR_MAX = PW'(DEPTH - 1);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [DEPTH-1:0] ctr_q, ctr_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PW'(1);
   endfunction

   assign full_o   = (ctr_q == CTR_MAX);
   assign empty_o  = (ctr_q == '0);
   assign ctr_o    = ctr_q;
   assign do_push  = push_i && !full_o;
   assign wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;

`ifdef SORTER_READ_PORT_EN
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] rdata_q;

   assign do_pop   = pop_i && !empty_o;
   assign rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
   assign rdata_o  = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         rdata_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         if (do_pop) rdata_q <= store_q[rd_ptr_q];
      end
   end
`else
   assign do_pop = 1'b0;
`endif

   always_comb begin
      ctr_d = ctr_q;
      if (do_push && !do_pop)      ctr_d = ctr_q + DEPTH'(1);
      else if (!do_push && do_pop) ctr_d = ctr_q - DEPTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         ctr_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         ctr_q    <= ctr_d;
      end
   end

   // Entry contents need no reset: the counter alone decides what is meaningful.
   always_ff @(posedge clk) begin
      if (do_push) store_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/axi_lite_data_sorter.sv
// rtl/axi_lite_data_sorter.sv - self-issuing AXI-Lite write sink sorting data by tag
// Optional FIFO read ports enabled by SORTER_READ_PORT_EN.
module axi_lite_data_sorter
   import sorter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      AWADDR,
   input  logic [WIDTH-1:0] WDATA,
   input  logic             val_wr_en,
   input  logic             ival_wr_en,
`ifdef SORTER_READ_PORT_EN
   input  logic             val_rd_en,
   input  logic             ival_rd_en,
   output logic [WIDTH-1:0] val_rdata,
   output logic [WIDTH-1:0] ival_rdata,
`endif
   output logic             AWVALID,
   output logic             WVALID,
   output logic             AWREADY,
   output logic             WREADY,
   output logic             BVALID,
   output logic             BREADY,
   output logic [1:0]       BRESP,
   output logic [0:WIDTH-1] mem,
   output logic [DEPTH-1:0] val_fifo_ctr,
   output logic [DEPTH-1:0] ival_fifo_ctr,
   output logic             val_full,
   output logic             val_empty,
   output logic             ival_full,
   output logic             ival_empty
);

   logic             is_mem, is_data, tag_ok;
   logic             val_push, ival_push;
   logic [1:0]       bresp_q, bresp_d;
   logic             bvalid_q;
   logic [WIDTH-1:0] mem_q, mem_d;

   // Handshakes track reset directly so the first edge after release already completes a write.
   assign AWVALID = rst;
   assign WVALID  = rst;
   assign AWREADY = rst;
   assign WREADY  = rst;
   assign BREADY  = rst;

   assign is_mem    = (AWADDR == ADDR_MEM);
   assign is_data   = (AWADDR == ADDR_DATA);
   assign tag_ok    = (WDATA[WIDTH-1 -: 8] == VALID_TAG);
   assign val_push  = is_data && tag_ok && val_wr_en;
   assign ival_push = is_data && !tag_ok && ival_wr_en;

   always_comb begin
      bresp_d = BRESP_SLVERR;
      mem_d   = mem_q;
      if (is_mem) begin
         bresp_d = BRESP_OKAY;
         mem_d   = WDATA;
      end else if (is_data) begin
         bresp_d = tag_ok ? push_resp(val_wr_en, val_full) : push_resp(ival_wr_en, ival_full);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bvalid_q <= 1'b0;
         bresp_q  <= BRESP_OKAY;
         mem_q    <= '0;
      end else begin
         bvalid_q <= 1'b1;
         bresp_q  <= bresp_d;
         mem_q    <= mem_d;
      end
   end

   assign BVALID = bvalid_q;
   assign BRESP  = bresp_q;
   assign mem    = mem_q;

   sorter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_val_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (val_push),
      .wdata_i (WDATA),
`ifdef SORTER_READ_PORT_EN
      .pop_i   (val_rd_en),
      .rdata_o (val_rdata),
`endif
      .ctr_o   (val_fifo_ctr),
      .full_o  (val_full),
      .empty_o (val_empty)
   );

   sorter_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ival_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (ival_push),
      .wdata_i (WDATA),
`ifdef SORTER_READ_PORT_EN
      .pop_i   (ival_rd_en),
      .rdata_o (ival_rdata),
`endif
      .ctr_o   (ival_fifo_ctr),
      .full_o  (ival_full),
      .empty_o (ival_empty)
   );

endmodule

// File: tb/tb_axi_lite_data_sorter.sv
// tb/tb_axi_lite_data_sorter.sv - directed and randomized bench for axi_lite_data_sorter
// Read-port steps run only when SORTER_READ_PORT_EN is defined.
module tb_axi_lite_data_sorter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 10;

   logic             clk;
   logic             rst;
   logic [31:0]      AWADDR;
   logic [WIDTH-1:0] WDATA;
   logic             val_wr_en, ival_wr_en;
   logic             AWVALID, WVALID, AWREADY, WREADY, BVALID, BREADY;
   logic [1:0]       BRESP;
   logic [0:WIDTH-1] mem;
   logic [DEPTH-1:0] val_fifo_ctr, ival_fifo_ctr;
   logic             val_full, val_empty, ival_full, ival_empty;
`ifdef SORTER_READ_PORT_EN
   logic             val_rd_en, ival_rd_en;
   logic [WIDTH-1:0] val_rdata, ival_rdata;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_mem;
   logic [31:0] val_q[$];
   logic [31:0] ival_q[$];
   logic [31:0] exp_val_rdata;

   axi_lite_data_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .AWADDR        (AWADDR),
      .WDATA         (WDATA),
      .val_wr_en     (val_wr_en),
      .ival_wr_en    (ival_wr_en),
`ifdef SORTER_READ_PORT_EN
      .val_rd_en     (val_rd_en),
      .ival_rd_en    (ival_rd_en),
      .val_rdata     (val_rdata),
      .ival_rdata    (ival_rdata),
`endif
      .AWVALID       (AWVALID),
      .WVALID        (WVALID),
      .AWREADY       (AWREADY),
      .WREADY        (WREADY),
      .BVALID        (BVALID),
      .BREADY        (BREADY),
      .BRESP         (BRESP),
      .mem           (mem),
      .val_fifo_ctr  (val_fifo_ctr),
      .ival_fifo_ctr (ival_fifo_ctr),
      .val_full      (val_full),
      .val_empty     (val_empty),
      .ival_full     (ival_full),
      .ival_empty    (ival_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("mem", mem, exp_mem);
      chk("val_ctr", val_fifo_ctr, val_q.size());
      chk("ival_ctr", ival_fifo_ctr, ival_q.size());
      chk("val_full", val_full, val_q.size() == DEPTH);
      chk("val_empty", val_empty, val_q.size() == 0);
      chk("ival_full", ival_full, ival_q.size() == DEPTH);
      chk("ival_empty", ival_empty, ival_q.size() == 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_handshake", {AWVALID, WVALID, AWREADY, WREADY, BREADY}, 5'b00000);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_bresp", BRESP, 2'b00);
      chk_state();
`ifdef SORTER_READ_PORT_EN
      chk("rst_val_rdata", val_rdata, 32'h0);
      chk("rst_ival_rdata", ival_rdata, 32'h0);
`endif
   endtask

   task automatic model_clear();
      exp_mem       = '0;
      exp_val_rdata = '0;
      val_q.delete();
      ival_q.delete();
   endtask

   // Called just after a negedge; asserts reset between edges and checks it acts without a clock.
   task automatic mid_reset();
      #2 rst = 1'b0;
      model_clear();
      #1 chk_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic ve, input logic ie);
      logic [1:0] exp_resp;
      AWADDR     = a;
      WDATA      = d;
      val_wr_en  = ve;
      ival_wr_en = ie;
      exp_resp   = 2'b10;
      if (a == 32'h0) begin
         exp_mem  = d;
         exp_resp = 2'b00;
      end else if (a == 32'h4) begin
         exp_resp = 2'b00;
         if (d[31:24] == 8'hA5) begin
            if (ve && val_q.size() >= DEPTH) exp_resp = 2'b10;
            else if (ve) val_q.push_back(d);
         end else begin
            if (ie && ival_q.size() >= DEPTH) exp_resp = 2'b10;
            else if (ie) ival_q.push_back(d);
         end
      end
      @(posedge clk);
      #1;
      chk("handshake", {AWVALID, WVALID, AWREADY, WREADY, BREADY}, 5'b11111);
      chk("bvalid", BVALID, 1'b1);
      chk("bresp", BRESP, exp_resp);
      chk_state();
      @(negedge clk);
   endtask

`ifdef SORTER_READ_PORT_EN
   task automatic do_val_read();
      AWADDR     = 32'h8;
      WDATA      = '0;
      val_wr_en  = 1'b0;
      ival_wr_en = 1'b0;
      val_rd_en  = 1'b1;
      if (val_q.size() > 0) exp_val_rdata = val_q.pop_front();
      @(posedge clk);
      #1;
      chk("val_rdata", val_rdata, exp_val_rdata);
      chk_state();
      @(negedge clk);
      val_rd_en = 1'b0;
   endtask
`endif

   initial begin
      logic [31:0] a, d;
      logic [7:0]  tag;
      rst        = 1'b1;
      AWADDR     = '0;
      WDATA      = '0;
      val_wr_en  = 1'b0;
      ival_wr_en = 1'b0;
`ifdef SORTER_READ_PORT_EN
      val_rd_en  = 1'b0;
      ival_rd_en = 1'b0;
`endif
      model_clear();
      #1 rst = 1'b0;
      #1 chk_reset_outputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Tag sorting: one valid, three invalid
      do_write(32'h4, 32'hA5000011, 1'b1, 1'b1);
      do_write(32'h4, 32'hA4000022, 1'b1, 1'b1);
      do_write(32'h4, 32'h00000033, 1'b1, 1'b1);
      do_write(32'h4, 32'hA2000044, 1'b1, 1'b1);
      chk("plan1_val", val_fifo_ctr, 32'd1);
      chk("plan1_ival", ival_fifo_ctr, 32'd3);

      // Mirror register, then the same word to the data port
      do_write(32'h0, 32'hA6000000, 1'b1, 1'b1);
      chk("plan2_mem", mem, 32'hA6000000);
      do_write(32'h4, 32'hA6000000, 1'b1, 1'b1);
      chk("plan2_ival", ival_fifo_ctr, 32'd4);

      // Fill valid FIFO from empty, then overflow
      mid_reset();
      for (int i = 0; i < DEPTH; i++) do_write(32'h4, 32'hA5000100 + i, 1'b1, 1'b1);
      chk("plan3_full", val_full, 1'b1);
      do_write(32'h4, 32'hA50001FF, 1'b1, 1'b1);
      chk("plan3_sat", val_fifo_ctr, 32'd10);
      chk("plan3_slverr", BRESP, 2'b10);

      // Disabled push and unmapped address
      mid_reset();
      do_write(32'h4, 32'hA5000200, 1'b0, 1'b1);
      chk("plan4_noen", val_fifo_ctr, 32'd0);
      do_write(32'h0, 32'h12345678, 1'b1, 1'b1);
      do_write(32'h8, 32'hA5000201, 1'b1, 1'b1);
      chk("plan4_slverr", BRESP, 2'b10);

      // Reset mid-stream, then the first edge after release takes a write
      do_write(32'h4, 32'h11000000, 1'b1, 1'b1);
      mid_reset();
      do_write(32'h4, 32'hA5000300, 1'b1, 1'b1);
      chk("plan5_first", val_fifo_ctr, 32'd1);

`ifdef SORTER_READ_PORT_EN
      mid_reset();
      do_write(32'h4, 32'hA5000001, 1'b1, 1'b1);
      do_write(32'h4, 32'hA5000002, 1'b1, 1'b1);
      do_val_read();
      chk("rd_first", val_rdata, 32'hA5000001);
      do_val_read();
      chk("rd_second", val_rdata, 32'hA5000002);
      chk("rd_empty", val_empty, 1'b1);
      do_val_read();
      chk("rd_hold", val_rdata, 32'hA5000002);
`endif

      // Randomized traffic with periodic resets
      mid_reset();
      for (int n = 0; n < 300; n++) begin
         if (n % 60 == 59) mid_reset();
         case ($urandom_range(0, 7))
            0:       a = 32'h0;
            6:       a = 32'h8;
            7:       a = $urandom_range(0, 15) << 2;
            default: a = 32'h4;
         endcase
         tag = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
         d   = {tag, 24'($urandom)};
         do_write(a, d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
